// File: rtl/mfp_timer_ng.sv
// mfp_timer_ng: MFP-style timer channel with delay, event and pulse-width modes, one-shot operation and sticky DONE.
module mfp_timer_ng #(
    parameter int WIDTH      = 8,
    parameter int TRIG_DEPTH = 8,
    parameter int PSC_WRAP   = 199
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             XCLK_EN,
    input  logic             DS,
    input  logic             DAT_WE,
    input  logic [WIDTH-1:0] DAT_I,
    output logic [WIDTH-1:0] DAT_O,
    input  logic             CTRL_WE,
    input  logic [5:0]       CTRL_I,
    output logic [4:0]       CTRL_O,
    input  logic             T_I,
    output logic             PULSE_MODE,
    output logic             EVENT_MODE,
    output logic             T_O,
    output logic             T_O_PULSE,
    output logic             DONE,
    output logic [WIDTH-1:0] SET_DATA_OUT
);
    localparam int HALF = TRIG_DEPTH / 2;
    localparam logic [7:0] WRAP = 8'(PSC_WRAP);
    localparam logic [TRIG_DEPTH-1:0] EDGE_PAT = {{HALF{1'b0}}, {HALF{1'b1}}};

    logic [4:0]            ctrl_q, ctrl_d;
    logic [WIDTH-1:0]      data_q, data_d, cnt_q, cnt_d, rd_q, rd_d;
    logic [7:0]            psc_q, psc_d, cmp;
    logic                  tick_q, tick_d, count_q, count_d;
    logic                  sync1_q, sync2_q, ds_q;
    logic [TRIG_DEPTH-1:0] shift_q, shift_d;
    logic                  t_o_q, t_o_d, pulse_q, done_q, done_d;
    logic [2:0]            sel;
    logic                  running, delay_m, event_m, pulse_m;
    logic                  psc_hit, trig_edge, trig_level, apply, timeout, one_shot_end;

    always_comb begin
        sel     = ctrl_q[2:0];
        running = ctrl_q[3:0] != 4'd0;
        delay_m = !ctrl_q[3] && sel != 3'd0;
        event_m = ctrl_q[3:0] == 4'b1000;
        pulse_m = ctrl_q[3] && sel != 3'd0;
        cmp = 8'd199;
        case (sel)
            3'd1: cmp = 8'd3;
            3'd2: cmp = 8'd9;
            3'd3: cmp = 8'd15;
            3'd4: cmp = 8'd49;
            3'd5: cmp = 8'd63;
            3'd6: cmp = 8'd99;
            default: cmp = 8'd199;
        endcase
    end

    // Prescaler and trigger filter both advance only on the timer-clock enable.
    always_comb begin
        psc_hit    = psc_q == cmp || psc_q == WRAP;
        psc_d      = sel == 3'd0 ? 8'd0 : !XCLK_EN ? psc_q : psc_hit ? 8'd0 : psc_q + 8'd1;
        tick_d     = sel != 3'd0 && XCLK_EN && psc_hit;
        shift_d    = XCLK_EN ? {shift_q[TRIG_DEPTH-2:0], sync2_q} : shift_q;
        trig_edge  = shift_q == EDGE_PAT;
        trig_level = &shift_q[HALF-1:0];
        count_d    = (delay_m && tick_q) || (event_m && XCLK_EN && trig_edge) ||
                     (pulse_m && tick_q && trig_level);
    end

    // A count pending when the timer has just been stopped is dropped so a stopped counter stays frozen.
    always_comb begin
        apply        = count_q && running;
        timeout      = apply && cnt_q == WIDTH'(1);
        one_shot_end = timeout && ctrl_q[4];
        data_d       = DAT_WE ? DAT_I : data_q;
        cnt_d        = timeout ? data_d : apply ? cnt_q - WIDTH'(1) :
                       (DAT_WE && !running) ? DAT_I : cnt_q;
        ctrl_d       = CTRL_WE ? CTRL_I[4:0] : one_shot_end ? 5'b10000 : ctrl_q;
        done_d       = CTRL_WE ? 1'b0 : one_shot_end || done_q;
        t_o_d        = (CTRL_WE && CTRL_I[5]) ? 1'b0 : t_o_q ^ timeout;
        rd_d         = (DS && !ds_q) ? cnt_q : rd_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            psc_q   <= '0;
            tick_q  <= 1'b0;
            count_q <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            shift_q <= '0;
            ds_q    <= 1'b0;
            t_o_q   <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            psc_q   <= psc_d;
            tick_q  <= tick_d;
            count_q <= count_d;
            sync1_q <= T_I;
            sync2_q <= sync1_q;
            shift_q <= shift_d;
            ds_q    <= DS;
            t_o_q   <= t_o_d;
            pulse_q <= timeout;
            done_q  <= done_d;
        end
    end

    assign DAT_O        = rd_q;
    assign CTRL_O       = ctrl_q;
    assign PULSE_MODE   = pulse_m;
    assign EVENT_MODE   = event_m;
    assign T_O          = t_o_q;
    assign T_O_PULSE    = pulse_q;
    assign DONE         = done_q;
    assign SET_DATA_OUT = data_q;
endmodule

// File: tb/tb_mfp_timer_ng.sv
// tb_mfp_timer_ng: directed table and sequences plus randomized run against a behavioural model.
module tb_mfp_timer_ng;
    localparam int W = 12, TD = 8, H = TD / 2, WRAP = 199;

    logic clk = 0, rst_n = 0, xen = 0, ds = 0, dat_we = 0, ctrl_we = 0, t_i = 0;
    logic [W-1:0] dat_i = 0, dat_o, set_data, r;
    logic [5:0] ctrl_i = 0;
    logic [4:0] ctrl_o;
    logic pulse_mode, event_mode, t_o, t_o_pulse, done;
    logic [33:0] outs;
    int total = 0, bad = 0, pulses = 0, n;

    always #5 clk = ~clk;

    mfp_timer_ng #(.WIDTH(W), .TRIG_DEPTH(TD), .PSC_WRAP(WRAP)) dut (
        .CLK(clk), .RST_N(rst_n), .XCLK_EN(xen), .DS(ds), .DAT_WE(dat_we), .DAT_I(dat_i),
        .DAT_O(dat_o), .CTRL_WE(ctrl_we), .CTRL_I(ctrl_i), .CTRL_O(ctrl_o), .T_I(t_i),
        .PULSE_MODE(pulse_mode), .EVENT_MODE(event_mode), .T_O(t_o), .T_O_PULSE(t_o_pulse),
        .DONE(done), .SET_DATA_OUT(set_data)
    );

    assign outs = {dat_o, ctrl_o, pulse_mode, event_mode, t_o, t_o_pulse, done, set_data};

    // Behavioural model: integer state updated once per clock from the timer rules.
    int divs[8] = '{0, 4, 10, 16, 50, 64, 100, 200};
    int m_ctrl, m_data, m_cnt, m_rd, m_psc, m_tick, m_pend, m_to, m_pulse, m_done, m_ds, m_s1, m_s2;
    bit m_hist[$];

    function automatic void m_reset();
        m_ctrl = 0; m_data = 0; m_cnt = 0; m_rd = 0; m_psc = 0; m_tick = 0; m_pend = 0;
        m_to = 0; m_pulse = 0; m_done = 0; m_ds = 0; m_s1 = 0; m_s2 = 0;
        m_hist.delete();
        for (int i = 0; i < TD; i++) m_hist.push_back(1'b0);
    endfunction

    function automatic void m_step();
        int sel, mode, nxt_pend, nxt_tick;
        bit run, edge_ok, level, applied, to, os;
        if (!rst_n) begin
            m_reset();
            return;
        end
        sel = m_ctrl % 8;
        mode = m_ctrl % 16;
        run = mode != 0;
        edge_ok = 1; level = 1;
        for (int i = 0; i < TD; i++) begin
            if (m_hist[i] != (i >= H)) edge_ok = 0;
            if (i >= H && !m_hist[i]) level = 0;
        end
        if (mode == 8) nxt_pend = int'(xen && edge_ok);
        else if (sel != 0 && mode < 8) nxt_pend = m_tick;
        else if (sel != 0) nxt_pend = int'(m_tick != 0 && level);
        else nxt_pend = 0;
        applied = m_pend != 0 && run;
        to = applied && m_cnt == 1;
        os = to && m_ctrl >= 16;
        if (ds && m_ds == 0) m_rd = m_cnt;
        m_ds = int'(ds);
        if (to) m_cnt = dat_we ? int'(dat_i) : m_data;
        else if (applied) m_cnt = (m_cnt + (1 << W) - 1) % (1 << W);
        else if (dat_we && !run) m_cnt = int'(dat_i);
        if (dat_we) m_data = int'(dat_i);
        nxt_tick = 0;
        if (sel == 0) m_psc = 0;
        else if (xen) begin
            if (m_psc == divs[sel] - 1 || m_psc == WRAP) begin
                m_psc = 0;
                nxt_tick = 1;
            end else m_psc++;
        end
        m_pulse = int'(to);
        if (ctrl_we && ctrl_i[5]) m_to = 0;
        else if (to) m_to = 1 - m_to;
        if (ctrl_we) begin
            m_ctrl = int'(ctrl_i[4:0]);
            m_done = 0;
        end else if (os) begin
            m_ctrl = 16;
            m_done = 1;
        end
        if (xen) begin
            void'(m_hist.pop_front());
            m_hist.push_back(m_s2 != 0);
        end
        m_s2 = m_s1;
        m_s1 = int'(t_i);
        m_pend = nxt_pend;
        m_tick = nxt_tick;
    endfunction

    function automatic logic [33:0] m_out();
        logic [4:0] c;
        c = 5'(m_ctrl);
        return {W'(m_rd), c, c[3] && c[2:0] != 3'd0, c[3:0] == 4'b1000,
                1'(m_to), 1'(m_pulse), 1'(m_done), W'(m_data)};
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        m_step();
        @(negedge clk);
        if (t_o_pulse) pulses++;
    endtask

    task automatic do_reset();
        rst_n = 0; dat_we = 0; ctrl_we = 0; ds = 0; xen = 1; t_i = 0;
        m_reset();
        cyc();
        cyc();
        rst_n = 1;
    endtask

    task automatic wr_data(input logic [W-1:0] v);
        dat_we = 1; dat_i = v;
        cyc();
        dat_we = 0;
    endtask

    task automatic wr_ctrl(input logic [5:0] v);
        ctrl_we = 1; ctrl_i = v;
        cyc();
        ctrl_we = 0;
    endtask

    task automatic read(output logic [W-1:0] v);
        ds = 1;
        cyc();
        v = dat_o;
        ds = 0;
        cyc();
    endtask

    task automatic wait_pulse(input int max, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!t_o_pulse && cnt < max);
        if (!t_o_pulse) cnt = -1;
    endtask

    typedef struct { logic [2:0] sel; logic [W-1:0] data; int period; } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{3'd1, 12'd3, 12};
        vecs[1] = '{3'd2, 12'd5, 50};
        vecs[2] = '{3'd3, 12'd1, 16};
        vecs[3] = '{3'd4, 12'd3, 150};
        vecs[4] = '{3'd5, 12'd1, 64};
        vecs[5] = '{3'd6, 12'd2, 200};
        vecs[6] = '{3'd7, 12'd2, 400};

        do_reset();
        rst_n = 0;
        #1 check("reset state", outs, 34'd0);
        do_reset();

        foreach (vecs[i]) begin
            do_reset();
            wr_data(vecs[i].data);
            wr_ctrl({3'b000, vecs[i].sel});
            wait_pulse(3000, n);
            check("first t_o", t_o, 1);
            wait_pulse(3000, n);
            check("delay period", n, vecs[i].period);
            check("second t_o", t_o, 0);
            read(r);
            check("reload value", r, vecs[i].data);
        end

        do_reset();
        wr_data(2);
        wr_ctrl(6'b001000);
        check("event mode flag", {event_mode, pulse_mode}, 2'b10);
        pulses = 0;
        repeat (12) cyc();
        t_i = 1;
        repeat (12) cyc();
        check("event no early timeout", pulses, 0);
        read(r);
        check("event one count", r, 1);
        t_i = 0;
        repeat (12) cyc();
        t_i = 1;
        repeat (12) cyc();
        check("event timeout 2nd edge", pulses, 1);
        check("event t_o", t_o, 1);

        do_reset();
        wr_data(2);
        wr_ctrl(6'b010001);
        wait_pulse(100, n);
        check("oneshot latency", n, 10);
        check("oneshot ctrl", ctrl_o, 5'b10000);
        check("oneshot done", done, 1);
        pulses = 0;
        repeat (60) cyc();
        check("oneshot no more", pulses, 0);
        check("oneshot done sticky", done, 1);
        wr_ctrl(6'b000000);
        check("done cleared", done, 0);

        do_reset();
        wr_data(12'h55);
        read(r);
        check("stopped load", r, 12'h55);
        wr_ctrl(6'b000001);
        wr_data(12'h22);
        read(r);
        check("running no load", r, 12'h55);
        check("data reg", set_data, 12'h22);
        wait_pulse(1000, n);
        read(r);
        check("reload new data", r, 12'h22);

        do_reset();
        wr_data(0);
        wr_ctrl(6'b000001);
        wait_pulse(20000, n);
        check("zero data latency", n, 16386);
        repeat (16383) cyc();
        ctrl_we = 1; ctrl_i = 6'b100001;
        cyc();
        ctrl_we = 0;
        check("force low at timeout", {t_o, t_o_pulse}, 2'b01);

        do_reset();
        wr_data(3);
        wr_ctrl(6'b000001);
        repeat (20) cyc();
        #2 rst_n = 0;
        m_reset();
        #1 check("async reset", outs, 34'd0);
        @(negedge clk);
        rst_n = 1;
        pulses = 0;
        wr_data(3);
        wr_ctrl(6'b000001);
        wait_pulse(100, n);
        check("post reset period", n, 14);
        check("post reset single pulse", pulses, 1);

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            xen = $urandom_range(0, 2) != 0;
            ds = $urandom_range(0, 3) == 0;
            dat_we = $urandom_range(0, 15) == 0;
            dat_i = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            ctrl_we = $urandom_range(0, 40) == 0;
            ctrl_i = 6'($urandom);
            if ($urandom_range(0, 7) == 0) t_i = ~t_i;
            cyc();
            check("random vs model", outs, m_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
